// File: rtl/pcie_cq_meta_hold.sv
// Registered MFB stage on the PCIe CQ path. It copies the per-frame CQ metadata onto every
// region of a frame, gives FBE/LBE the same layout for every vendor, and counts framing violations.
module pcie_cq_meta_hold #(
    parameter int    MFB_REGIONS     = 2,
    parameter int    MFB_REGION_SIZE = 1,
    parameter int    MFB_BLOCK_SIZE  = 8,
    parameter int    MFB_ITEM_WIDTH  = 32,
    parameter string DEVICE          = "ULTRASCALE",
    parameter int    META_W          = 182,
    localparam int   DATA_W    = MFB_REGIONS * MFB_REGION_SIZE * MFB_BLOCK_SIZE * MFB_ITEM_WIDTH,
    localparam int   SOF_POS_W = (MFB_REGION_SIZE > 1) ? $clog2(MFB_REGION_SIZE) : 1,
    localparam int   EOF_POS_W = (MFB_REGION_SIZE * MFB_BLOCK_SIZE > 1) ?
                                 $clog2(MFB_REGION_SIZE * MFB_BLOCK_SIZE) : 1
) (
    input  logic                             CLK,
    input  logic                             RESET,

    input  logic [DATA_W-1:0]                RX_MFB_DATA,
    input  logic [MFB_REGIONS*META_W-1:0]    RX_MFB_META,
    input  logic [MFB_REGIONS-1:0]           RX_MFB_SOF,
    input  logic [MFB_REGIONS-1:0]           RX_MFB_EOF,
    input  logic [MFB_REGIONS*SOF_POS_W-1:0] RX_MFB_SOF_POS,
    input  logic [MFB_REGIONS*EOF_POS_W-1:0] RX_MFB_EOF_POS,
    input  logic                             RX_MFB_SRC_RDY,
    output logic                             RX_MFB_DST_RDY,

    output logic [DATA_W-1:0]                TX_MFB_DATA,
    output logic [MFB_REGIONS*META_W-1:0]    TX_MFB_META,
    output logic [MFB_REGIONS-1:0]           TX_MFB_SOF,
    output logic [MFB_REGIONS-1:0]           TX_MFB_EOF,
    output logic [MFB_REGIONS*SOF_POS_W-1:0] TX_MFB_SOF_POS,
    output logic [MFB_REGIONS*EOF_POS_W-1:0] TX_MFB_EOF_POS,
    output logic [MFB_REGIONS*4-1:0]         TX_MFB_FBE,
    output logic [MFB_REGIONS*4-1:0]         TX_MFB_LBE,
    output logic                             TX_MFB_SRC_RDY,
    input  logic                             TX_MFB_DST_RDY,

    output logic [15:0]                      ERR_CNT
);

    localparam int BLK_SHIFT  = $clog2(MFB_BLOCK_SIZE);
    localparam bit INTEL_MODE = (DEVICE == "STRATIX10") || (DEVICE == "AGILEX");

    logic                                 in_frame;
    logic [META_W-1:0]                    hold_meta;
    logic                                 accept;
    logic [MFB_REGIONS-1:0][META_W-1:0]   own_meta;
    logic [MFB_REGIONS-1:0][3:0]          fbe;
    logic [MFB_REGIONS-1:0][3:0]          lbe;
    logic [META_W-1:0]                    meta_run;
    logic                                 frame_run;
    logic                                 violation;
    logic                                 sof_first;

    assign RX_MFB_DST_RDY = TX_MFB_DST_RDY || !TX_MFB_SRC_RDY;
    assign accept         = RX_MFB_SRC_RDY && RX_MFB_DST_RDY;

    // Regions are walked in ascending order. Each region either starts a new owner or inherits the previous one.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the loop can infer a latch.
        meta_run  = hold_meta;
        frame_run = in_frame;
        violation = !in_frame && !(|{RX_MFB_SOF, RX_MFB_EOF});
        sof_first = 1'b0;
        own_meta  = '0;
        fbe       = '0;
        lbe       = '0;
        for (int i = 0; i < MFB_REGIONS; i++) begin
            if (RX_MFB_SOF[i])
                meta_run = RX_MFB_META[i*META_W +: META_W];
            own_meta[i] = meta_run;
            if (INTEL_MODE) begin
                fbe[i] = meta_run[35:32];
                lbe[i] = meta_run[39:36];
            end else begin
                fbe[i] = meta_run[166:163];
                lbe[i] = meta_run[170:167];
            end

            sof_first = 32'(RX_MFB_SOF_POS[i*SOF_POS_W +: SOF_POS_W])
                     <= (32'(RX_MFB_EOF_POS[i*EOF_POS_W +: EOF_POS_W]) >> BLK_SHIFT);
            if (RX_MFB_SOF[i] && RX_MFB_EOF[i]) begin
                if (sof_first) begin
                    violation = violation || frame_run;
                    frame_run = 1'b0;
                end else begin
                    violation = violation || !frame_run;
                    frame_run = 1'b1;
                end
            end else if (RX_MFB_SOF[i]) begin
                violation = violation || frame_run;
                frame_run = 1'b1;
            end else if (RX_MFB_EOF[i]) begin
                violation = violation || !frame_run;
                frame_run = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: all sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (RESET) begin
            TX_MFB_SRC_RDY <= 1'b0;
            TX_MFB_DATA    <= '0;
            TX_MFB_META    <= '0;
            TX_MFB_SOF     <= '0;
            TX_MFB_EOF     <= '0;
            TX_MFB_SOF_POS <= '0;
            TX_MFB_EOF_POS <= '0;
            TX_MFB_FBE     <= '0;
            TX_MFB_LBE     <= '0;
            in_frame       <= 1'b0;
            hold_meta      <= '0;
            ERR_CNT        <= '0;
        end else begin
            if (RX_MFB_DST_RDY) begin
                TX_MFB_SRC_RDY <= RX_MFB_SRC_RDY;
                TX_MFB_DATA    <= RX_MFB_DATA;
                TX_MFB_META    <= own_meta;
                TX_MFB_SOF     <= RX_MFB_SOF;
                TX_MFB_EOF     <= RX_MFB_EOF;
                TX_MFB_SOF_POS <= RX_MFB_SOF_POS;
                TX_MFB_EOF_POS <= RX_MFB_EOF_POS;
                TX_MFB_FBE     <= fbe;
                TX_MFB_LBE     <= lbe;
            end
            if (accept) begin
                in_frame  <= frame_run;
                hold_meta <= meta_run;
                if (violation && ERR_CNT != 16'hFFFF)
                    ERR_CNT <= ERR_CNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_cq_meta_hold.sv
// Self-checking bench for pcie_cq_meta_hold. A Xilinx-mode and an Intel-mode instance share the same
// stimulus, and both are compared every cycle against a frame-level reference model.
module tb_pcie_cq_meta_hold;

    localparam int R   = 2;
    localparam int RS  = 1;
    localparam int BS  = 8;
    localparam int IW  = 32;
    localparam int MW  = 182;
    localparam int DW  = R * RS * BS * IW;
    localparam int SPW = 1;
    localparam int EPW = 3;

    typedef logic [R-1:0][MW-1:0] meta_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [DW-1:0]    rx_data    = '0;
    logic [R*MW-1:0]  rx_meta    = '0;
    logic [R-1:0]     rx_sof     = '0;
    logic [R-1:0]     rx_eof     = '0;
    logic [R*SPW-1:0] rx_sof_pos = '0;
    logic [R*EPW-1:0] rx_eof_pos = '0;
    logic             rx_src_rdy = 1'b0;
    logic             tx_dst_rdy = 1'b1;

    logic             x_rx_dst_rdy, i_rx_dst_rdy;
    logic [DW-1:0]    x_tx_data, i_tx_data;
    logic [R*MW-1:0]  x_tx_meta, i_tx_meta;
    logic [R-1:0]     x_tx_sof, i_tx_sof, x_tx_eof, i_tx_eof;
    logic [R*SPW-1:0] x_tx_sof_pos, i_tx_sof_pos;
    logic [R*EPW-1:0] x_tx_eof_pos, i_tx_eof_pos;
    logic [R*4-1:0]   x_tx_fbe, i_tx_fbe, x_tx_lbe, i_tx_lbe;
    logic             x_tx_src_rdy, i_tx_src_rdy;
    logic [15:0]      x_err, i_err;

    pcie_cq_meta_hold #(
        .MFB_REGIONS(R), .MFB_REGION_SIZE(RS), .MFB_BLOCK_SIZE(BS),
        .MFB_ITEM_WIDTH(IW), .DEVICE("ULTRASCALE"), .META_W(MW)
    ) dut_x (
        .CLK(clk), .RESET(rst),
        .RX_MFB_DATA(rx_data), .RX_MFB_META(rx_meta), .RX_MFB_SOF(rx_sof), .RX_MFB_EOF(rx_eof),
        .RX_MFB_SOF_POS(rx_sof_pos), .RX_MFB_EOF_POS(rx_eof_pos),
        .RX_MFB_SRC_RDY(rx_src_rdy), .RX_MFB_DST_RDY(x_rx_dst_rdy),
        .TX_MFB_DATA(x_tx_data), .TX_MFB_META(x_tx_meta), .TX_MFB_SOF(x_tx_sof), .TX_MFB_EOF(x_tx_eof),
        .TX_MFB_SOF_POS(x_tx_sof_pos), .TX_MFB_EOF_POS(x_tx_eof_pos),
        .TX_MFB_FBE(x_tx_fbe), .TX_MFB_LBE(x_tx_lbe),
        .TX_MFB_SRC_RDY(x_tx_src_rdy), .TX_MFB_DST_RDY(tx_dst_rdy),
        .ERR_CNT(x_err)
    );

    pcie_cq_meta_hold #(
        .MFB_REGIONS(R), .MFB_REGION_SIZE(RS), .MFB_BLOCK_SIZE(BS),
        .MFB_ITEM_WIDTH(IW), .DEVICE("AGILEX"), .META_W(MW)
    ) dut_i (
        .CLK(clk), .RESET(rst),
        .RX_MFB_DATA(rx_data), .RX_MFB_META(rx_meta), .RX_MFB_SOF(rx_sof), .RX_MFB_EOF(rx_eof),
        .RX_MFB_SOF_POS(rx_sof_pos), .RX_MFB_EOF_POS(rx_eof_pos),
        .RX_MFB_SRC_RDY(rx_src_rdy), .RX_MFB_DST_RDY(i_rx_dst_rdy),
        .TX_MFB_DATA(i_tx_data), .TX_MFB_META(i_tx_meta), .TX_MFB_SOF(i_tx_sof), .TX_MFB_EOF(i_tx_eof),
        .TX_MFB_SOF_POS(i_tx_sof_pos), .TX_MFB_EOF_POS(i_tx_eof_pos),
        .TX_MFB_FBE(i_tx_fbe), .TX_MFB_LBE(i_tx_lbe),
        .TX_MFB_SRC_RDY(i_tx_src_rdy), .TX_MFB_DST_RDY(tx_dst_rdy),
        .ERR_CNT(i_err)
    );

    always #5 clk = ~clk;

    // Reference model state: the word the TX side should currently present, plus frame tracking.
    bit               m_valid   = 1'b0;
    logic [DW-1:0]    m_data    = '0;
    logic [R-1:0]     m_sof     = '0;
    logic [R-1:0]     m_eof     = '0;
    logic [R*SPW-1:0] m_sof_pos = '0;
    logic [R*EPW-1:0] m_eof_pos = '0;
    meta_vec_t        m_meta    = '0;
    bit               m_inframe = 1'b0;
    logic [MW-1:0]    m_hold    = '0;
    int               m_err     = 0;

    bit chk_en   = 1'b0;
    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_out    = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Owner of region i = the last SOF at or before i in this word, otherwise the held frame meta.
    // Violations come from walking the word's boundary events in the order they occur in time.
    function automatic void model_word(output meta_vec_t own, output bit nf, output bit v);
        int ev[$];
        int last;
        int s_item;
        int e_item;
        nf = m_inframe;
        v  = 1'b0;
        for (int i = 0; i < R; i++) begin
            last = -1;
            for (int j = 0; j <= i; j++)
                if (rx_sof[j]) last = j;
            own[i] = (last < 0) ? m_hold : rx_meta[last*MW +: MW];
        end
        for (int i = 0; i < R; i++) begin
            s_item = int'(rx_sof_pos[i*SPW +: SPW]) * BS;
            e_item = int'(rx_eof_pos[i*EPW +: EPW]);
            if (rx_sof[i] && rx_eof[i] && s_item > e_item) begin
                ev.push_back(0);
                ev.push_back(1);
            end else begin
                if (rx_sof[i]) ev.push_back(1);
                if (rx_eof[i]) ev.push_back(0);
            end
        end
        if (ev.size() == 0 && !m_inframe) v = 1'b1;
        foreach (ev[k]) begin
            if (ev[k] == 1) begin
                if (nf) v = 1'b1;
                nf = 1'b1;
            end else begin
                if (!nf) v = 1'b1;
                nf = 1'b0;
            end
        end
    endfunction

    // One clock cycle: predict from the driven inputs, let the edge happen, commit the prediction.
    task automatic step();
        bit        load;
        bit        acc;
        bit        nf;
        bit        v;
        meta_vec_t own;
        load = tx_dst_rdy || !m_valid;
        acc  = rx_src_rdy && load && !rst;
        own  = '0;
        nf   = 1'b0;
        v    = 1'b0;
        if (acc) model_word(own, nf, v);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid   = 1'b0;
            m_inframe = 1'b0;
            m_hold    = '0;
            m_err     = 0;
        end else begin
            if (load) begin
                m_valid = rx_src_rdy;
                if (rx_src_rdy) begin
                    m_data    = rx_data;
                    m_sof     = rx_sof;
                    m_eof     = rx_eof;
                    m_sof_pos = rx_sof_pos;
                    m_eof_pos = rx_eof_pos;
                    m_meta    = own;
                end
            end
            if (acc) begin
                n_acc++;
                m_inframe = nf;
                m_hold    = own[R-1];
                if (v && m_err < 65535) m_err++;
            end
        end
    endtask

    function automatic logic [MW-1:0] mk_meta(input logic [3:0] fbe, input logic [3:0] lbe,
                                              input logic [2:0] bar, input logic [7:0] hbe);
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        r[166:163] = fbe;
        r[170:167] = lbe;
        r[162:160] = bar;
        r[39:32]   = hbe;
        return r[MW-1:0];
    endfunction

    function automatic logic [MW-1:0] rnd_meta();
        return mk_meta(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    endfunction

    task automatic rnd_data();
        for (int k = 0; k < DW / 32; k++) rx_data[k*32 +: 32] = $urandom();
    endtask

    task automatic drive(input logic [R-1:0] sof, input logic [R-1:0] eof,
                         input logic [MW-1:0] m0, input logic [MW-1:0] m1);
        rx_src_rdy = 1'b1;
        rx_sof     = sof;
        rx_eof     = eof;
        rx_meta    = {m1, m0};
        rx_sof_pos = '0;
        rx_eof_pos = 6'($urandom_range(0, 63));
        rnd_data();
        step();
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_src_rdy", x_tx_src_rdy, m_valid);
            check("i_tx_src_rdy", i_tx_src_rdy, m_valid);
            check("rx_dst_rdy", x_rx_dst_rdy, tx_dst_rdy || !m_valid);
            check("i_rx_dst_rdy", i_rx_dst_rdy, tx_dst_rdy || !m_valid);
            check("err_cnt", x_err, m_err[15:0]);
            check("i_err_cnt", i_err, m_err[15:0]);
            if (m_valid) begin
                check("tx_data", x_tx_data, m_data);
                check("tx_sof", x_tx_sof, m_sof);
                check("tx_eof", x_tx_eof, m_eof);
                check("tx_sof_pos", x_tx_sof_pos, m_sof_pos);
                check("tx_eof_pos", x_tx_eof_pos, m_eof_pos);
                for (int i = 0; i < R; i++) begin
                    check("tx_meta", x_tx_meta[i*MW +: MW], m_meta[i]);
                    check("i_tx_meta", i_tx_meta[i*MW +: MW], m_meta[i]);
                    check("x_fbe", x_tx_fbe[i*4 +: 4], m_meta[i][166:163]);
                    check("x_lbe", x_tx_lbe[i*4 +: 4], m_meta[i][170:167]);
                    check("i_fbe", i_tx_fbe[i*4 +: 4], m_meta[i][35:32]);
                    check("i_lbe", i_tx_lbe[i*4 +: 4], m_meta[i][39:36]);
                end
            end
            if (x_tx_src_rdy && tx_dst_rdy) n_out++;
        end
    end

    initial begin
        logic [MW-1:0] mf;
        logic [MW-1:0] ma;
        logic [MW-1:0] mb;
        logic [DW-1:0] sd;
        bit            gen_f;
        bit            f;
        logic [R-1:0]  s;
        logic [R-1:0]  e;

        rst = 1'b1;
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;
        check("lit_reset_src_rdy", x_tx_src_rdy, 1'b0);
        check("lit_reset_err", x_err, 16'd0);
        check("lit_reset_data", x_tx_data, '0);
        check("lit_reset_meta", x_tx_meta, '0);
        check("lit_reset_fbe", {x_tx_fbe, x_tx_lbe}, 16'h0000);

        // Data word with no SOF straight after reset: one violation, meta taken from the cleared holder.
        drive(2'b00, 2'b00, rnd_meta(), rnd_meta());
        check("lit_nosof_err", x_err, 16'd1);
        check("lit_nosof_meta", x_tx_meta, '0);

        // Two SOFs with no EOF between them.
        drive(2'b01, 2'b00, rnd_meta(), rnd_meta());
        check("lit_sof1_err", x_err, 16'd1);
        drive(2'b01, 2'b00, rnd_meta(), rnd_meta());
        check("lit_sof2_err", x_err, 16'd2);
        drive(2'b00, 2'b01, rnd_meta(), rnd_meta());

        // Three-word frame: FBE=F, LBE=3 (Xilinx field), HEADER[39:32]=5A (Intel field).
        mf = mk_meta(4'hF, 4'h3, 3'd0, 8'h5A);
        for (int w = 0; w < 3; w++) begin
            case (w)
                0:       drive(2'b01, 2'b00, mf, rnd_meta());
                1:       drive(2'b00, 2'b00, rnd_meta(), rnd_meta());
                default: drive(2'b00, 2'b10, rnd_meta(), rnd_meta());
            endcase
            check("lit_frame_meta", x_tx_meta, {mf, mf});
            check("lit_x_fbe", x_tx_fbe, 8'hFF);
            check("lit_x_lbe", x_tx_lbe, 8'h33);
            check("lit_i_fbe", i_tx_fbe, 8'hAA);
            check("lit_i_lbe", i_tx_lbe, 8'h55);
        end
        check("lit_frame_err", x_err, 16'd2);

        // EOF of frame A and SOF of frame B in the same word.
        ma = mk_meta(4'h1, 4'h2, 3'd1, 8'h00);
        mb = mk_meta(4'h4, 4'h8, 3'd2, 8'h00);
        drive(2'b01, 2'b00, ma, rnd_meta());
        drive(2'b10, 2'b01, rnd_meta(), mb);
        check("lit_ab_bar0", x_tx_meta[160 +: 3], 3'd1);
        check("lit_ab_bar1", x_tx_meta[MW+160 +: 3], 3'd2);
        drive(2'b00, 2'b01, rnd_meta(), rnd_meta());
        check("lit_b_next_bar0", x_tx_meta[160 +: 3], 3'd2);
        check("lit_ab_err", x_err, 16'd2);

        // Backpressure for 5 cycles in the middle of a frame.
        drive(2'b01, 2'b00, rnd_meta(), rnd_meta());
        sd         = x_tx_data;
        tx_dst_rdy = 1'b0;
        rnd_data();
        rx_sof = 2'b00;
        rx_eof = 2'b00;
        for (int c = 0; c < 5; c++) begin
            step();
            check("lit_stall_rx_rdy", x_rx_dst_rdy, 1'b0);
            check("lit_stall_data", x_tx_data, sd);
        end
        tx_dst_rdy = 1'b1;
        step();
        check("lit_release_data", x_tx_data, rx_data);
        drive(2'b00, 2'b01, rnd_meta(), rnd_meta());

        // Reset for one cycle mid-frame.
        drive(2'b01, 2'b00, rnd_meta(), rnd_meta());
        rst        = 1'b1;
        rx_src_rdy = 1'b0;
        step();
        rst = 1'b0;
        check("lit_midrst_src_rdy", x_tx_src_rdy, 1'b0);
        check("lit_midrst_err", x_err, 16'd0);
        drive(2'b00, 2'b00, rnd_meta(), rnd_meta());
        check("lit_midrst_meta", x_tx_meta, '0);
        check("lit_midrst_err1", x_err, 16'd1);

        // Random traffic: first a mostly-legal frame generator, then unconstrained markers.
        gen_f = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            s = '0;
            e = '0;
            if (c < 1500) begin
                f = gen_f;
                for (int i = 0; i < R; i++) begin
                    if (f) begin
                        if ($urandom_range(0, 2) == 0) begin
                            e[i] = 1'b1;
                            f    = 1'b0;
                        end
                    end else if ($urandom_range(0, 1) == 0) begin
                        s[i] = 1'b1;
                        if ($urandom_range(0, 2) == 0) e[i] = 1'b1;
                        else f = 1'b1;
                    end
                end
                if (!gen_f && s == '0 && e == '0) begin
                    s[0] = 1'b1;
                    f    = 1'b1;
                end
            end else begin
                s = 2'($urandom_range(0, 3));
                e = 2'($urandom_range(0, 3));
                f = gen_f;
            end
            rx_src_rdy = ($urandom_range(0, 3) != 0);
            tx_dst_rdy = ($urandom_range(0, 3) != 0);
            rx_sof     = s;
            rx_eof     = e;
            rx_meta    = {rnd_meta(), rnd_meta()};
            rx_sof_pos = '0;
            rx_eof_pos = 6'($urandom_range(0, 63));
            rnd_data();
            if (rx_src_rdy && (tx_dst_rdy || !m_valid)) gen_f = f;
            step();
        end

        rx_src_rdy = 1'b0;
        tx_dst_rdy = 1'b1;
        step();
        step();
        check("scoreboard_words", n_out, n_acc);

        // Saturation: more than 65535 violating words after a reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rx_sof = '0;
        rx_eof = '0;
        rx_src_rdy = 1'b1;
        for (int c = 0; c < 65540; c++) step();
        check("lit_sat_err", x_err, 16'hFFFF);
        check("lit_sat_err_i", i_err, 16'hFFFF);

        rx_src_rdy = 1'b0;
        step();
        step();
        check("scoreboard_words_end", n_out, n_acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
